// File: rtl/riscv_lsu_bridge.sv
// riscv_lsu_bridge: MEM-stage load/store to word-aligned req/ack bus bridge.
// Core side: addr_i, wdata_i, rd_en_i, wr_en_i, size_i, unsigned_i in;
//   rdata_o (registered, extended), stall_o (comb), err_o (1-cycle pulse) out.
// Bus side: bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o out;
//   bus_ack_i, bus_rdata_i, bus_err_i in.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip
//   the bus and report err_o; otherwise the low address bits are dropped.
module riscv_lsu_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;

  logic [1:0]        off;
  logic [3:0]        be_n;
  logic [31:0]       wd_n;
  logic [7:0]        lb;
  logic [15:0]       lh;
  logic [31:0]       ext;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              mis;
`endif

  // Lane offset after dropping the bits an access of this size ignores.
  always_comb begin
    off  = addr_i[1:0];
    be_n = 4'b1111;
    wd_n = wdata_i;
    case (size_i)
      2'b00: begin
        be_n = 4'b0001 << off;
        wd_n = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        off  = {addr_i[1], 1'b0};
        be_n = 4'b0011 << off;
        wd_n = {2{wdata_i[15:0]}};
      end
      default: off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    case (size_i)
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_i[0];
      default: mis = |addr_i[1:0];
    endcase
  end
`endif

  always_comb begin
    lb  = 8'(bus_rdata_i >> {off_q, 3'b000});
    lh  = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    ext = bus_rdata_i;
    case (size_q)
      2'b00:   ext = {{24{~uns_q & lb[7]}}, lb};
      2'b01:   ext = {{16{~uns_q & lh[15]}}, lh};
      default: ext = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    uns_d   = uns_q;
    off_d   = off_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_en_i | wr_en_i) begin
          addr_d  = ADDR_W'({addr_i[31:2], 2'b00});
          be_d    = be_n;
          wdata_d = wd_n;
          // A simultaneous load and store is treated as the store.
          we_d    = wr_en_i;
          uns_d   = unsigned_i;
          off_d   = off;
          size_d  = size_i;
          state_d = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (mis) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
`endif
        end
      end
      REQ: begin
        if (bus_ack_i) begin
          state_d = DONE;
          if (bus_err_i) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (!we_q) begin
            rdata_d = ext;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      size_q  <= size_d;
    end
  end

  assign stall_o     = (rd_en_i | wr_en_i) & (state_q != DONE);
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_riscv_lsu_bridge.sv
// tb_riscv_lsu_bridge: directed and randomized checks of riscv_lsu_bridge
// against a behavioural load/store model; honours LSU_MISALIGN_TRAP_EN.
module tb_riscv_lsu_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [1:0]  size = '0;
  logic        uns = 1'b0;
  logic [31:0] rdata_o;
  logic        stall_o, err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  int nchk = 0;
  int nfail = 0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  riscv_lsu_bridge #(.ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .addr_i(addr), .wdata_i(wdata),
    .rd_en_i(rd_en), .wr_en_i(wr_en),
    .size_i(size), .unsigned_i(uns),
    .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
    .bus_err_i(bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    bit          stable;
    int          reqc;
    int          stallc;
    logic [31:0] rdata;
    int          errc;
    bit          err_done;
    bit          tmo;
  } obs_t;

  // Drive one access, act as bus slave acking after dly request cycles,
  // and collect what the DUT did. No judging happens here.
  task automatic run_access(input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input bit us,
                            input int dly, input bit berr,
                            input logic [31:0] bw, output obs_t o);
    bit done;
    o = '{default: 0};
    o.stable = 1'b1;
    o.tmo = 1'b1;
    done = 1'b0;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; addr = a; wdata = wd; size = sz; uns = us;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (err_o) o.errc++;
      if (bus_req_o) begin
        if (o.reqc == 0) begin
          o.addr = bus_addr_o; o.be = bus_be_o;
          o.we = bus_we_o; o.wdata = bus_wdata_o;
        end else if ({bus_addr_o, bus_be_o, bus_we_o, bus_wdata_o}
                     !== {o.addr, o.be, o.we, o.wdata}) begin
          o.stable = 1'b0;
        end
        if (o.reqc == dly) begin
          bus_ack = 1'b1; bus_err = berr; bus_rdata = bw;
        end
        o.reqc++;
      end
      if (stall_o) o.stallc++;
      else begin
        o.rdata = rdata_o; o.err_done = err_o; done = 1'b1;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (done) begin
        o.tmo = 1'b0;
        break;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    if (err_o) o.errc++;
  endtask

  // Behavioural expectation from the access rules, plus rdata history.
  function automatic obs_t model(bit wr, logic [31:0] a, logic [31:0] wd,
                                 logic [1:0] sz, bit us, int dly, bit berr,
                                 logic [31:0] bw);
    obs_t e;
    int unsigned off, v;
    e = '{default: 0};
    e.stable = 1'b1;
    e.we = wr;
    off = a % 4;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((sz == 1 && off % 2 == 1) || (sz >= 2 && off != 0)) begin
      e.stallc = 1; e.errc = 1; e.err_done = 1'b1;
      m_rdata = '0; e.rdata = '0;
      return e;
    end
`endif
    if (sz == 1) off = off - off % 2;
    else if (sz >= 2) off = 0;
    e.addr = a - a % 4;
    if (sz == 0) begin
      e.be = 4'(1 << off);
      e.wdata = (wd % 256) * 32'h01010101;
      v = (bw >> (8 * off)) % 256;
      if (!us && v > 127) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      e.be = 4'(3 << off);
      e.wdata = (wd % 65536) * 32'h00010001;
      v = (bw >> (8 * off)) % 65536;
      if (!us && v > 32767) v = v + 32'hFFFF0000;
    end else begin
      e.be = 4'hF; e.wdata = wd; v = bw;
    end
    e.stallc = dly + 2;
    e.reqc = dly + 1;
    if (berr) begin
      e.errc = 1; e.err_done = 1'b1; m_rdata = '0;
    end else if (!wr) begin
      m_rdata = v;
    end
    e.rdata = m_rdata;
    return e;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    nchk++; if (rdata_o !== 32'h0) begin nfail++; $display("FAIL reset_rdata: got %h exp 0", rdata_o); end
    nchk++; if ({bus_req_o, bus_we_o, err_o, stall_o} !== 4'b0) begin nfail++; $display("FAIL reset_ctl: got %b exp 0000", {bus_req_o, bus_we_o, err_o, stall_o}); end
    nchk++; if ({bus_addr_o, bus_be_o, bus_wdata_o} !== 68'h0) begin nfail++; $display("FAIL reset_bus: got %h %h %h exp 0", bus_addr_o, bus_be_o, bus_wdata_o); end
    rst = 1'b0;
  endtask

  task automatic test_word_load;
    obs_t o;
    run_access(1, 0, 32'h100, 0, 2'b10, 0, 0, 0, 32'hDEADBEEF, o);
    m_rdata = 32'hDEADBEEF;
    nchk++; if (o.addr !== 32'h100 || o.be !== 4'hF) begin nfail++; $display("FAIL wload_bus: got %h %b exp 00000100 1111", o.addr, o.be); end
    nchk++; if (o.rdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL wload_rdata: got %h exp deadbeef", o.rdata); end
    nchk++; if (o.stallc !== 2 || o.tmo) begin nfail++; $display("FAIL wload_stall: got %0d tmo %0d exp 2", o.stallc, o.tmo); end
  endtask

  task automatic test_byte_load;
    obs_t o;
    run_access(1, 0, 32'h203, 0, 2'b00, 0, 0, 0, 32'h80123456, o);
    nchk++; if (o.be !== 4'b1000) begin nfail++; $display("FAIL bload_be: got %b exp 1000", o.be); end
    nchk++; if (o.rdata !== 32'hFFFFFF80) begin nfail++; $display("FAIL bload_signed: got %h exp ffffff80", o.rdata); end
    run_access(1, 0, 32'h203, 0, 2'b00, 1, 0, 0, 32'h80123456, o);
    m_rdata = 32'h80;
    nchk++; if (o.rdata !== 32'h00000080) begin nfail++; $display("FAIL bload_unsigned: got %h exp 00000080", o.rdata); end
  endtask

  task automatic test_half_store;
    obs_t o;
    run_access(0, 1, 32'h402, 32'h0000ABCD, 2'b01, 0, 3, 0, 32'h0, o);
    nchk++; if (o.we !== 1'b1 || o.be !== 4'b1100) begin nfail++; $display("FAIL hstore_we_be: got %b %b exp 1 1100", o.we, o.be); end
    nchk++; if (o.wdata !== 32'hABCDABCD) begin nfail++; $display("FAIL hstore_wdata: got %h exp abcdabcd", o.wdata); end
    nchk++; if (!o.stable || o.reqc !== 4) begin nfail++; $display("FAIL hstore_hold: got stable %0d reqc %0d exp 1 4", o.stable, o.reqc); end
    nchk++; if (o.stallc !== 5) begin nfail++; $display("FAIL hstore_stall: got %0d exp 5", o.stallc); end
    nchk++; if (o.rdata !== 32'h80) begin nfail++; $display("FAIL hstore_rdata_kept: got %h exp 00000080", o.rdata); end
  endtask

  task automatic test_bus_error;
    obs_t o;
    run_access(1, 0, 32'h500, 0, 2'b10, 0, 1, 1, 32'h55AA55AA, o);
    m_rdata = '0;
    nchk++; if (o.rdata !== 32'h0) begin nfail++; $display("FAIL berr_rdata: got %h exp 0", o.rdata); end
    nchk++; if (o.errc !== 1 || !o.err_done) begin nfail++; $display("FAIL berr_pulse: got cnt %0d in_done %0d exp 1 1", o.errc, o.err_done); end
  endtask

  task automatic test_misalign;
    obs_t o;
    run_access(1, 0, 32'h102, 0, 2'b10, 0, 0, 0, 32'h13579BDF, o);
`ifdef LSU_MISALIGN_TRAP_EN
    m_rdata = '0;
    nchk++; if (o.reqc !== 0 || o.stallc !== 1) begin nfail++; $display("FAIL mis_trap: got reqc %0d stall %0d exp 0 1", o.reqc, o.stallc); end
    nchk++; if (o.errc !== 1 || !o.err_done || o.rdata !== 32'h0) begin nfail++; $display("FAIL mis_err: got cnt %0d rdata %h exp 1 0", o.errc, o.rdata); end
`else
    m_rdata = 32'h13579BDF;
    nchk++; if (o.addr !== 32'h100 || o.be !== 4'hF) begin nfail++; $display("FAIL mis_align: got %h %b exp 00000100 1111", o.addr, o.be); end
    nchk++; if (o.errc !== 0 || o.rdata !== 32'h13579BDF) begin nfail++; $display("FAIL mis_data: got err %0d rdata %h exp 0 13579bdf", o.errc, o.rdata); end
`endif
  endtask

  task automatic test_reset_mid;
    obs_t o;
    int n;
    run_access(1, 0, 32'h300, 0, 2'b10, 0, 0, 0, 32'h12345678, o);
    nchk++; if (o.rdata !== 32'h12345678) begin nfail++; $display("FAIL rmid_pre: got %h exp 12345678", o.rdata); end
    @(posedge clk); #1;
    addr = 32'h304; size = 2'b10; rd_en = 1'b1;
    n = 0;
    while (!bus_req_o && n < 10) begin @(negedge clk); n++; end
    nchk++; if (bus_req_o !== 1'b1) begin nfail++; $display("FAIL rmid_req: got %b exp 1", bus_req_o); end
    #2 rst = 1'b1;
    #1;
    nchk++; if (bus_req_o !== 1'b0 || rdata_o !== 32'h0) begin nfail++; $display("FAIL rmid_async: got req %b rdata %h exp 0 0", bus_req_o, rdata_o); end
    rd_en = 1'b0;
    m_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    run_access(1, 0, 32'h308, 0, 2'b10, 0, 0, 0, 32'hCAFEF00D, o);
    m_rdata = 32'hCAFEF00D;
    nchk++; if (o.rdata !== 32'hCAFEF00D || o.reqc !== 1 || o.stallc !== 2) begin nfail++; $display("FAIL rmid_after: got %h reqc %0d stall %0d exp cafef00d 1 2", o.rdata, o.reqc, o.stallc); end
  endtask

  task automatic test_random;
    obs_t o, e;
    bit rd, wr, us, berr;
    logic [31:0] a, wd, bw;
    logic [1:0] sz;
    int dly, op;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      rd = (op != 2); wr = (op >= 2);
      a = $urandom_range(0, 32'hFFF);
      wd = $urandom; bw = $urandom;
      sz = 2'($urandom_range(0, 3));
      us = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 3);
      berr = !wr && ($urandom_range(0, 7) == 0);
      e = model(wr, a, wd, sz, us, dly, berr, bw);
      run_access(rd, wr, a, wd, sz, us, dly, berr, bw, o);
      nchk++; if (o.tmo || o.stallc !== e.stallc) begin nfail++; $display("FAIL rand_stall #%0d: got %0d tmo %0d exp %0d", i, o.stallc, o.tmo, e.stallc); end
      nchk++; if (o.reqc !== e.reqc) begin nfail++; $display("FAIL rand_reqc #%0d: got %0d exp %0d", i, o.reqc, e.reqc); end
      nchk++; if (o.rdata !== e.rdata) begin nfail++; $display("FAIL rand_rdata #%0d: got %h exp %h", i, o.rdata, e.rdata); end
      nchk++; if (o.errc !== e.errc || o.err_done !== e.err_done) begin nfail++; $display("FAIL rand_err #%0d: got %0d/%0d exp %0d/%0d", i, o.errc, o.err_done, e.errc, e.err_done); end
      if (e.reqc > 0) begin
        nchk++; if (o.addr !== e.addr || o.be !== e.be) begin nfail++; $display("FAIL rand_addr_be #%0d: got %h %b exp %h %b", i, o.addr, o.be, e.addr, e.be); end
        nchk++; if (o.we !== e.we || !o.stable) begin nfail++; $display("FAIL rand_we #%0d: got %b stable %0d exp %b", i, o.we, o.stable, e.we); end
        if (wr) begin
          nchk++; if (o.wdata !== e.wdata) begin nfail++; $display("FAIL rand_wdata #%0d: got %h exp %h", i, o.wdata, e.wdata); end
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_word_load;
    test_byte_load;
    test_half_store;
    test_bus_error;
    test_misalign;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
